// File: rtl/inst_sram_responder.sv
// inst_sram_responder
//   Responder end of the inst_sram fetch interface. Fetch requests (en/addr)
//   read an internal word array at accept time. The words travel through a
//   LATENCY-deep pipe and land in a response FIFO, which the decode stage
//   drains with resp_ready. A credit count covering the pipe and the FIFO keeps
//   the FIFO from ever overflowing. flush drops all older work and keeps a
//   request accepted in the same cycle.
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_sram_en      fetch request valid
//   inst_sram_addr    fetch byte address
//   inst_sram_ready   request accepted when en && ready
//   inst_sram_rvalid  response valid at FIFO head
//   inst_sram_rdata   instruction word (0 on error)
//   inst_sram_rerr    misaligned / out-of-range response
//   resp_ready        consumer pops head when rvalid && resp_ready
//   flush             discard all outstanding work accepted before this edge
//   init_we/addr/wdata  preload port into the word array
module inst_sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'hbfc00000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_sram_en,
  input  logic [31:0]           inst_sram_addr,
  output logic                  inst_sram_ready,
  output logic                  inst_sram_rvalid,
  output logic [31:0]           inst_sram_rdata,
  output logic                  inst_sram_rerr,
  input  logic                  resp_ready,
  input  logic                  flush,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_wdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FIFO_DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST_C   = PW'(FIFO_DEPTH - 1);

  // FIFO_DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_LAST_C) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  logic [31:0]           mem_r [WORDS];
  logic [31:0]           off_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  hit_s;
  logic                  accept_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ready_s;

  logic [LATENCY-1:0]    pv_r;
  logic [LATENCY-1:0]    pe_r;
  logic [31:0]           pd_r [LATENCY];

  logic [31:0]           fd_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fe_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         out_cnt_r;

  logic [31:0]           hold_d_r;
  logic                  hold_e_r;

  // Address decode: 32-bit unsigned offset; a low address cannot wrap into a hit.
  always_comb begin
    off_s = inst_sram_addr - ADDR_BASE;
    idx_s = off_s[DEPTH_LOG2+1:2];
    hit_s = (inst_sram_addr >= ADDR_BASE) &&
            ((off_s >> (DEPTH_LOG2 + 2)) == 32'd0) &&
            (inst_sram_addr[1:0] == 2'b00);
  end

  // Handshakes: a pop in the same cycle frees a credit for a new request.
  always_comb begin
    pop_s    = (cnt_r != '0) && resp_ready;
    ready_s  = (out_cnt_r < FIFO_DEPTH_C) || pop_s;
    accept_s = inst_sram_en && ready_s;
    push_s   = pv_r[LATENCY-1] && !flush;
  end

  assign inst_sram_ready  = ready_s;
  assign inst_sram_rvalid = (cnt_r != '0);
  assign inst_sram_rdata  = (cnt_r != '0) ? fd_r[rd_ptr_r] : hold_d_r;
  assign inst_sram_rerr   = (cnt_r != '0) ? fe_r[rd_ptr_r] : hold_e_r;

  // Preload port; the array is not reset. The read at accept sees the old word.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_r[init_addr] <= init_wdata;
    end
  end

  // Latency pipe: stage 0 captures the array read; flush kills older stages only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd_r[i] <= 32'd0;
      end
    end else begin
      pv_r[0] <= accept_s;
      pe_r[0] <= !hit_s;
      pd_r[0] <= hit_s ? mem_r[idx_s] : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pv_r[i] <= pv_r[i-1] && !flush;
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  // Response FIFO; flush empties it, including a head popped at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      fe_r     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fd_r[i] <= 32'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        fd_r[wr_ptr_r] <= pd_r[LATENCY-1];
        fe_r[wr_ptr_r] <= pe_r[LATENCY-1];
        wr_ptr_r       <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Outstanding credit count: pipe entries plus FIFO entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_r <= '0;
    end else if (flush) begin
      out_cnt_r <= accept_s ? CW'(1) : CW'(0);
    end else begin
      case ({accept_s, pop_s})
        2'b10:   out_cnt_r <= out_cnt_r + CW'(1);
        2'b01:   out_cnt_r <= out_cnt_r - CW'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // Last popped head is shown while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_d_r <= 32'd0;
      hold_e_r <= 1'b0;
    end else if (pop_s) begin
      hold_d_r <= fd_r[rd_ptr_r];
      hold_e_r <= fe_r[rd_ptr_r];
    end else begin
      hold_d_r <= hold_d_r;
      hold_e_r <= hold_e_r;
    end
  end

endmodule
